// File: rtl/threshold_sequencer.sv
// threshold_sequencer: streams one DEPTHxDEPTH coefficient block into the thresholder and holds
// its captured result on a valid/ready port. Define THR_SEQ_WDOG_EN to add the DRAIN watchdog.
module threshold_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned COL_W   = $clog2(DEPTH),
    parameter int unsigned INDEX_W = 2 * COL_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             clear,
    output logic                             busy,
    output logic                             err,
    output logic                             mem_rd_en,
    output logic [COL_W-1:0]                 mem_rd_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]      mem_rd_data,
    output logic                             thr_valid_in,
    output logic [DEPTH-1:0][WIDTH-1:0]      thr_data_in,
    input  logic                             thr_valid_out,
    input  logic [3:0][WIDTH-1:0]            thr_max_values,
    input  logic [3:0][INDEX_W-1:0]          thr_index,
    input  logic [WIDTH-1:0]                 thr_dc_value,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [3:0][WIDTH-1:0]            res_max_values,
    output logic [3:0][INDEX_W-1:0]          res_index,
    output logic [WIDTH-1:0]                 res_dc_value,
    output logic                             blk_irq
);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic              abort_pend, abort_pend_nxt;
    logic              busy_nxt, err_nxt, mem_rd_en_nxt, res_valid_nxt, blk_irq_nxt;
    logic              capture_c;
    logic              abort_c;
    logic              wdog_to_c;

    // A pending or same-cycle clear turns the block into a discard run.
    assign abort_c = abort_pend || clear;

`ifdef THR_SEQ_WDOG_EN
    localparam int unsigned       WDOG_W    = 3;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(3);
    logic [WDOG_W-1:0] wdog;

    // Counts cycles spent in DRAIN; the fourth silent cycle gives up on the thresholder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 wdog <= '0;
        else if (state == DRAIN)  wdog <= wdog + WDOG_W'(1);
        else                      wdog <= '0;
    end

    assign wdog_to_c = (state == DRAIN) && !thr_valid_out && (wdog == WDOG_LAST);
`else
    assign wdog_to_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !clear) state_nxt = STREAM;
            end
            STREAM: begin
                // Never truncated: the thresholder expects exactly DEPTH columns.
                if (col == LAST_COL) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (thr_valid_out)  state_nxt = abort_c ? IDLE : HOLD;
                else if (wdog_to_c) state_nxt = IDLE;
            end
            HOLD: begin
                if (clear || res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        capture_c      = (state == DRAIN) && thr_valid_out && !abort_c;
        busy_nxt       = (state_nxt != IDLE);
        mem_rd_en_nxt  = (state_nxt == STREAM);
        col_nxt        = '0;
        abort_pend_nxt = abort_pend;
        res_valid_nxt  = res_valid;
        blk_irq_nxt    = capture_c;
        err_nxt        = err;

        if (state == STREAM && state_nxt == STREAM) col_nxt = col + COL_W'(1);

        if (state_nxt == IDLE)                               abort_pend_nxt = 1'b0;
        else if (clear && (state == STREAM || state == DRAIN)) abort_pend_nxt = 1'b1;

        if (capture_c)                                  res_valid_nxt = 1'b1;
        else if (state == HOLD && (clear || res_ready)) res_valid_nxt = 1'b0;

        if (clear)
            err_nxt = 1'b0;
        else if ((start && state != IDLE) || (thr_valid_out && state != DRAIN) || wdog_to_c)
            err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col          <= '0;
            abort_pend   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            mem_rd_en    <= 1'b0;
            thr_valid_in <= 1'b0;
            res_valid    <= 1'b0;
            blk_irq      <= 1'b0;
        end else begin
            col          <= col_nxt;
            abort_pend   <= abort_pend_nxt;
            busy         <= busy_nxt;
            err          <= err_nxt;
            mem_rd_en    <= mem_rd_en_nxt;
            thr_valid_in <= mem_rd_en;
            res_valid    <= res_valid_nxt;
            blk_irq      <= blk_irq_nxt;
        end
    end

    // Result registers only move on a non-aborted capture, so clear in HOLD keeps old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_max_values <= '0;
            res_index      <= '0;
            res_dc_value   <= '0;
        end else if (capture_c) begin
            res_max_values <= thr_max_values;
            res_index      <= thr_index;
            res_dc_value   <= thr_dc_value;
        end
    end

    assign mem_rd_addr = col;

    // Read data arrives one cycle after the strobe, aligned with thr_valid_in; passed straight through.
    assign thr_data_in = thr_valid_in ? mem_rd_data : '0;

endmodule
